load_store_unit: RTL and testbench

- Sits between the core's memory-stage datapath and the byte-addressed, word-wide data memory.
- Accepts one load/store request at a time and supports byte, halfword and word accesses.
- Loads are sign- or zero-extended. Sub-word stores use a read-modify-write sequence, so the memory only ever sees aligned 32-bit writes.
- Detects misaligned and out-of-range accesses, suppresses any memory access for them, and reports an error with the response.

---
 rtl/load_store_unit_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 41 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and error bits.
package load_store_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned ERR_ALIGN = 0;
   localparam int unsigned ERR_RANGE = 1;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StMergeWr,
      StResp
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load lane extract/extend and sub-word store merge.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      half_sel = word_i[{off_i[1], 4'b0000} +: 16];
   end

   always_comb begin
      load_o = word_i;
      unique case (size_i)
         SZ_BYTE: load_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_HALF: load_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_o = word_i;
      endcase
   end

   // Untouched lanes keep the word read back from memory.
   always_comb begin
      merge_o = word_i;
      unique case (size_i)
         SZ_BYTE: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
         SZ_HALF: merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: merge_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; sub-word stores are done as read-modify-write.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 32,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write_en,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   localparam logic [ADDR_W:0] LastByte = (ADDR_W+1)'(MEM_BYTES - 1);

   lsu_state_e        state_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   logic              req_ready_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic [1:0]        resp_err_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic              mem_write_en_q;
   logic [31:0]       mem_write_data_q;

   logic              misaligned;
   logic              out_of_range;
   logic [1:0]        err_d;
   logic [31:0]       load_data;
   logic [31:0]       merged_word;

   always_comb begin
      unique case (req_size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = req_addr[0];
         SZ_WORD: misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
      // Last byte of the containing word, widened so the +3 cannot wrap.
      out_of_range = {1'b0, req_addr[ADDR_W-1:2], 2'b11} > LastByte;
      err_d = 2'b00;
      err_d[ERR_ALIGN] = misaligned;
      err_d[ERR_RANGE] = out_of_range;
   end

   lsu_lane_align u_lane_align (
      .word_i     (mem_read_data),
      .off_i      (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .load_o     (load_data),
      .merge_o    (merged_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         we_q             <= 1'b0;
         size_q           <= 2'b00;
         uns_q            <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= 32'h0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= 32'h0;
         resp_err_q       <= 2'b00;
         mem_address_q    <= '0;
         mem_write_en_q   <= 1'b0;
         mem_write_data_q <= 32'h0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid && req_ready_q) begin
                  we_q        <= req_we;
                  size_q      <= req_size;
                  uns_q       <= req_unsigned;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  if (|err_d) begin
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= 32'h0;
                     resp_err_q   <= err_d;
                     state_q      <= StResp;
                  end else begin
                     mem_address_q <= {req_addr[ADDR_W-1:2], 2'b00};
                     // Full-word stores need no read, so strobe during ACCESS.
                     if (req_we && (req_size == SZ_WORD)) begin
                        mem_write_en_q   <= 1'b1;
                        mem_write_data_q <= req_wdata;
                     end
                     state_q <= StAccess;
                  end
               end
            end
            StAccess: begin
               mem_write_en_q <= 1'b0;
               if (!we_q) begin
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= load_data;
                  state_q      <= StResp;
               end else if (size_q == SZ_WORD) begin
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= 32'h0;
                  state_q      <= StResp;
               end else begin
                  mem_write_en_q   <= 1'b1;
                  mem_write_data_q <= merged_word;
                  state_q          <= StMergeWr;
               end
            end
            StMergeWr: begin
               mem_write_en_q <= 1'b0;
               resp_valid_q   <= 1'b1;
               resp_rdata_q   <= 32'h0;
               state_q        <= StResp;
            end
            StResp: begin
               resp_valid_q <= 1'b0;
               resp_rdata_q <= 32'h0;
               resp_err_q   <= 2'b00;
               req_ready_q  <= 1'b1;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;
   assign mem_address    = mem_address_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, response scoreboard, reset abort.
module tb_load_store_unit;

   localparam int unsigned MEM_BYTES = 32;
   localparam int unsigned ADDR_W    = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] mem_address;
   logic        mem_write_en;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [8];
   int          wr_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   load_store_unit #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_address    (mem_address),
      .mem_write_en   (mem_write_en),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   assign mem_read_data = mem[mem_address[4:2]];

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[mem_address[4:2]] <= mem_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
      int          wr;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
   } exp_t;

   vec_t vecs[19];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      req_we       = v.we;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_valid    = 1'b1;
   endtask

   task automatic run_req(input vec_t v, input string tag);
      int   w0;
      int   n;
      bit   got;
      exp_t e;
      @(negedge clk);
      check($sformatf("%s ready", tag), 32'(req_ready), 32'd1);
      drive(v);
      sb.push_back('{v.rdata, v.err, v.lat});
      w0 = wr_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         if (resp_valid) got = 1'b1;
         else check($sformatf("%s busy_ready", tag), 32'(req_ready), 32'd0);
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s timeout: no resp_valid within %0d cycles, expected at %0d",
                  tag, n, v.lat);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check($sformatf("%s rdata", tag), resp_rdata, e.rdata);
         check($sformatf("%s err", tag), 32'(resp_err), 32'(e.err));
         check($sformatf("%s latency", tag), 32'(n), 32'(e.lat));
      end
      @(negedge clk);
      check($sformatf("%s pulse", tag), 32'(resp_valid), 32'd0);
      check($sformatf("%s ready_after", tag), 32'(req_ready), 32'd1);
      check($sformatf("%s writes", tag), 32'(wr_cnt - w0), 32'(v.wr));
   endtask

   initial begin
      int   pulses;
      int   first_k;
      int   last_k;
      int   w0;
      vec_t v;

      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      mem[1] = 32'h8899AABB;
      mem[7] = 32'h11223344;

      //          we    size   uns   addr    wdata          rdata          err    lat wr
      vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h05, 32'h0,        32'hFFFFFFAA, 2'b00, 2, 0};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h07, 32'h0,        32'h00000088, 2'b00, 2, 0};
      vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h06, 32'h0,        32'hFFFF8899, 2'b00, 2, 0};
      vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h04, 32'h0,        32'h0000AABB, 2'b00, 2, 0};
      vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h06, 32'h123456CC, 32'h0,        2'b00, 3, 1};
      vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h88CCAABB, 2'b00, 2, 0};
      vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF,     32'h0,        2'b01, 1, 0};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h88CCAABB, 2'b00, 2, 0};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h0,        2'b10, 1, 0};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h1C, 32'h0,        32'h11223344, 2'b00, 2, 0};
      vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0,        2'b00, 2, 1};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 2'b00, 2, 0};
      vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        2'b01, 1, 0};
      vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h1F, 32'h0,        32'h00000011, 2'b00, 2, 0};
      vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h0A, 32'h1234BEEF, 32'h0,        2'b00, 3, 1};
      vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'hFFFFBEEF, 2'b00, 2, 0};
      vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        32'h0,        2'b11, 1, 0};
      vecs[17] = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h55,       32'h0,        2'b10, 1, 0};
      vecs[18] = '{1'b0, 2'b01, 1'b1, 32'h1E, 32'h0,        32'h00001122, 2'b00, 2, 0};

      // Reset values while rst_n is held low.
      #12;
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_rdata", resp_rdata, 32'h0);
      check("rst resp_err", 32'(resp_err), 32'd0);
      check("rst mem_write_en", 32'(mem_write_en), 32'd0);
      check("rst mem_address", mem_address, 32'h0);
      check("rst mem_write_data", mem_write_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) run_req(vecs[i], $sformatf("vec%0d", i));
      check("word04 after SB", mem[1], 32'h88CCAABB);
      check("word08 after SH", mem[2], 32'hBEEFBEEF);

      // Held request: back-to-back loads, one accept every three cycles.
      v = vecs[9];
      @(negedge clk);
      w0 = wr_cnt;
      drive(v);
      pulses = 0;
      first_k = 0;
      last_k = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            pulses++;
            if (first_k == 0) first_k = k;
            last_k = k;
            check($sformatf("b2b rdata%0d", pulses), resp_rdata, 32'h11223344);
         end
      end
      req_valid = 1'b0;
      check("b2b pulses", 32'(pulses), 32'd3);
      check("b2b first", 32'(first_k), 32'd2);
      check("b2b last", 32'(last_k), 32'd8);
      @(negedge clk);
      check("b2b idle ready", 32'(req_ready), 32'd1);
      check("b2b idle valid", 32'(resp_valid), 32'd0);
      check("b2b writes", 32'(wr_cnt - w0), 32'd0);

      // Reset asserted while the merged SB write is being strobed.
      @(negedge clk);
      v = '{1'b1, 2'b00, 1'b0, 32'h06, 32'h00000077, 32'h0, 2'b00, 3, 1};
      w0 = wr_cnt;
      drive(v);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw access we", 32'(mem_write_en), 32'd0);
      @(negedge clk);
      check("rmw merge we", 32'(mem_write_en), 32'd1);
      check("rmw merge data", mem_write_data, 32'h8877AABB);
      #2 rst_n = 1'b0;
      #1;
      check("abort we", 32'(mem_write_en), 32'd0);
      check("abort ready", 32'(req_ready), 32'd1);
      check("abort valid", 32'(resp_valid), 32'd0);
      check("abort addr", mem_address, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort mem", mem[1], 32'h88CCAABB);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      check("abort no resp", 32'(pulses), 32'd0);
      check("abort writes", 32'(wr_cnt - w0), 32'd0);
      check("abort idle ready", 32'(req_ready), 32'd1);
      run_req(vecs[5], "post_abort LW");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
